// File: rtl/fifo_ctrl_if.sv
// rtl/fifo_ctrl_if.sv - requester/RAM handshake bundle for the FIFO controller
interface fifo_ctrl_if #(
   parameter int AW = 3
);
   logic          push;
   logic          pop;
   logic [AW-1:0] addrw;
   logic [AW-1:0] addrr;
   logic [1:0]    rw;
   logic          valid_out;

   modport master (
      output push,
      output pop,
      input  addrw,
      input  addrr,
      input  rw,
      input  valid_out
   );

   modport slave (
      input  push,
      input  pop,
      output addrw,
      output addrr,
      output rw,
      output valid_out
   );
endinterface

// File: rtl/fifo_ctrl.sv
// rtl/fifo_ctrl.sv - FIFO pointer/occupancy controller driving an external dual-port RAM
module fifo_ctrl #(
   parameter int AW         = 3,
   parameter int AF_DEFAULT = 6,
   parameter int AE_DEFAULT = 2
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          init,
   input  logic [AW:0]   th_af,
   input  logic [AW:0]   th_ae,
   fifo_ctrl_if.slave    bus,
   output logic [AW:0]   count,
   output logic          full,
   output logic          empty,
   output logic          almost_full,
   output logic          almost_empty,
   output logic          error,
   output logic [2:0]    state
);

   typedef enum logic [2:0] {
      S_RESET  = 3'd0,
      S_INIT   = 3'd1,
      S_IDLE   = 3'd2,
      S_ACTIVE = 3'd3,
      S_ERROR  = 3'd4
   } state_t;

   localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

   state_t        st;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   th_af_reg;
   logic [AW:0]   th_ae_reg;
   logic          valid_q;
   logic          op_ok;
   logic          push_acc;
   logic          pop_acc;
   logic          overflow;
   logic          underflow;
   logic [AW:0]   count_nxt;

   // Flags follow occupancy directly so they react in the same cycle as count
   assign full         = (count == DEPTH);
   assign empty        = (count == '0);
   assign almost_full  = (count >= th_af_reg);
   assign almost_empty = (count <= th_ae_reg);

   // init wins over any request, so nothing is accepted while it is high
   assign op_ok     = ((st == S_IDLE) || (st == S_ACTIVE)) && !init;
   assign push_acc  = op_ok && bus.push && !full;
   assign pop_acc   = op_ok && bus.pop  && !empty;
   assign overflow  = op_ok && bus.push && full;
   assign underflow = op_ok && bus.pop  && empty;

   assign bus.rw        = {pop_acc, push_acc};
   assign bus.addrw     = wr_ptr;
   assign bus.addrr     = rd_ptr;
   assign bus.valid_out = valid_q;
   assign state         = st;

   // Next occupancy: a simultaneous push and pop leaves it unchanged
   always_comb begin
      count_nxt = count;
      if (push_acc && !pop_acc) begin
         count_nxt = count + (AW+1)'(1);
      end else if (pop_acc && !push_acc) begin
         count_nxt = count - (AW+1)'(1);
      end
   end

   // Control FSM with pointers, occupancy, thresholds and sticky error
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         st        <= S_RESET;
         wr_ptr    <= '0;
         rd_ptr    <= '0;
         count     <= '0;
         error     <= 1'b0;
         valid_q   <= 1'b0;
         th_af_reg <= (AW+1)'(AF_DEFAULT);
         th_ae_reg <= (AW+1)'(AE_DEFAULT);
      end else begin
         // RAM read data appears one cycle after the accepted pop
         valid_q <= pop_acc;
         if (st == S_RESET) begin
            st <= S_INIT;
         end else if (init) begin
            st        <= S_INIT;
            th_af_reg <= th_af;
            th_ae_reg <= th_ae;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            error     <= 1'b0;
         end else begin
            case (st)
               S_INIT: begin
                  st <= S_IDLE;
               end
               S_IDLE, S_ACTIVE: begin
                  if (push_acc) begin
                     wr_ptr <= wr_ptr + AW'(1);
                  end
                  if (pop_acc) begin
                     rd_ptr <= rd_ptr + AW'(1);
                  end
                  count <= count_nxt;
                  // Any op accepted alongside the bad request still completes
                  if (overflow || underflow) begin
                     error <= 1'b1;
                     st    <= S_ERROR;
                  end else if (count_nxt == '0) begin
                     st <= S_IDLE;
                  end else begin
                     st <= S_ACTIVE;
                  end
               end
               S_ERROR: begin
                  error <= 1'b1;
               end
               default: begin
                  st <= S_RESET;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_fifo_ctrl.sv
// tb/tb_fifo_ctrl.sv - directed self-checking bench for fifo_ctrl
module tb_fifo_ctrl;
   localparam int AW = 3;

   logic          clk = 1'b0;
   logic          reset;
   logic          init;
   logic [AW:0]   th_af;
   logic [AW:0]   th_ae;
   logic [AW:0]   count;
   logic          full;
   logic          empty;
   logic          almost_full;
   logic          almost_empty;
   logic          error;
   logic [2:0]    state;

   int n_vec = 0;
   int n_bad = 0;

   fifo_ctrl_if #(.AW(AW)) bus ();

   fifo_ctrl #(.AW(AW), .AF_DEFAULT(6), .AE_DEFAULT(2)) dut (
      .clk          (clk),
      .reset        (reset),
      .init         (init),
      .th_af        (th_af),
      .th_ae        (th_ae),
      .bus          (bus.slave),
      .count        (count),
      .full         (full),
      .empty        (empty),
      .almost_full  (almost_full),
      .almost_empty (almost_empty),
      .error        (error),
      .state        (state)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      n_vec++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_init();
      init = 1'b1;
      tick();
      check("init_state", int'(state), 1);
      check("init_count", int'(count), 0);
      check("init_error", int'(error), 0);
      init = 1'b0;
      tick();
      check("idle_state", int'(state), 2);
   endtask

   initial begin
      reset    = 1'b0;
      init     = 1'b0;
      th_af    = 4'd5;
      th_ae    = 4'd1;
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      #12;
      check("rst_state", int'(state), 0);
      check("rst_count", int'(count), 0);
      check("rst_empty", int'(empty), 1);
      check("rst_full", int'(full), 0);
      check("rst_ae", int'(almost_empty), 1);
      check("rst_af", int'(almost_full), 0);
      check("rst_rw", int'(bus.rw), 0);
      check("rst_addrw", int'(bus.addrw), 0);
      check("rst_addrr", int'(bus.addrr), 0);
      check("rst_error", int'(error), 0);
      check("rst_valid", int'(bus.valid_out), 0);

      // leave reset with init held, thresholds 5/1
      init  = 1'b1;
      reset = 1'b1;
      tick();
      check("r2i_state", int'(state), 1);
      tick();
      check("hold_init", int'(state), 1);
      init = 1'b0;
      tick();
      check("i2idle", int'(state), 2);

      // eight pushes fill the FIFO
      bus.push = 1'b1;
      for (int i = 0; i < 8; i++) begin
         #1;
         check("fill_addrw", int'(bus.addrw), i);
         check("fill_rw", int'(bus.rw), 1);
         tick();
         check("fill_count", int'(count), i + 1);
         check("fill_af", int'(almost_full), (i + 1 >= 5) ? 1 : 0);
         check("fill_ae", int'(almost_empty), (i + 1 <= 1) ? 1 : 0);
         check("fill_state", int'(state), 3);
      end
      check("full_flag", int'(full), 1);
      check("wrap_addrw", int'(bus.addrw), 0);

      // ninth push overflows
      #1;
      check("ovf_rw", int'(bus.rw), 0);
      tick();
      check("ovf_count", int'(count), 8);
      check("ovf_error", int'(error), 1);
      check("ovf_state", int'(state), 4);
      bus.pop = 1'b1;
      #1;
      check("err_ignore_rw", int'(bus.rw), 0);
      bus.push = 1'b0;
      bus.pop  = 1'b0;

      // three pushes then a simultaneous push and pop
      do_init();
      bus.push = 1'b1;
      repeat (3) tick();
      check("p3_count", int'(count), 3);
      bus.pop = 1'b1;
      #1;
      check("pp_rw", int'(bus.rw), 3);
      check("pp_addrw", int'(bus.addrw), 3);
      check("pp_addrr", int'(bus.addrr), 0);
      tick();
      check("pp_count", int'(count), 3);
      check("pp_valid", int'(bus.valid_out), 1);
      check("pp_state", int'(state), 3);
      bus.push = 1'b0;
      bus.pop  = 1'b0;
      tick();
      check("valid_drop", int'(bus.valid_out), 0);

      // pop on empty
      do_init();
      bus.pop = 1'b1;
      #1;
      check("udf_rw", int'(bus.rw), 0);
      tick();
      check("udf_error", int'(error), 1);
      check("udf_state", int'(state), 4);
      check("udf_count", int'(count), 0);
      bus.pop = 1'b0;

      // push and pop together on empty
      do_init();
      bus.push = 1'b1;
      bus.pop  = 1'b1;
      #1;
      check("ppe_rw", int'(bus.rw), 1);
      tick();
      check("ppe_count", int'(count), 1);
      check("ppe_error", int'(error), 1);
      check("ppe_state", int'(state), 4);
      bus.push = 1'b0;
      bus.pop  = 1'b0;

      // reset mid-stream at count 4
      do_init();
      bus.push = 1'b1;
      repeat (4) tick();
      check("pre_rst_count", int'(count), 4);
      #1;
      reset = 1'b0;
      #1;
      check("mrst_count", int'(count), 0);
      check("mrst_empty", int'(empty), 1);
      check("mrst_rw", int'(bus.rw), 0);
      check("mrst_state", int'(state), 0);
      check("mrst_addrw", int'(bus.addrw), 0);
      bus.push = 1'b0;
      tick();
      reset = 1'b1;
      tick();
      check("post_rst_state", int'(state), 1);
      check("post_rst_count", int'(count), 0);
      check("post_rst_rw", int'(bus.rw), 0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule

// File: doc/fifo_ctrl.md
FIFO_CTRL -- requirements
Module: fifo_ctrl

Interface
REQ-001 SHALL have parameter AW, default 3, RAM address width; FIFO depth = 2^AW.
REQ-002 SHALL have parameter AF_DEFAULT, default 6, almost-full threshold after reset.
REQ-003 SHALL have parameter AE_DEFAULT, default 2, almost-empty threshold after reset.
REQ-004 SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port init  input  1  enter/hold INIT, latch thresholds.
REQ-007 SHALL have port th_af  input  AW+1  almost-full threshold, sampled in INIT.
REQ-008 SHALL have port th_ae  input  AW+1  almost-empty threshold, sampled in INIT.
REQ-009 SHALL have port push  input  1  write request; the RAM's data_in is driven directly by the requester.
REQ-010 SHALL have port pop  input  1  read request.
REQ-011 SHALL have port addrw  output  AW  RAM write address (write pointer).
REQ-012 SHALL have port addrr  output  AW  RAM read address (read pointer).
REQ-013 SHALL have port rw  output  2  RAM command; rw[0]=write enable, rw[1]=read enable.
REQ-014 SHALL have port count  output  AW+1  current occupancy.
REQ-015 SHALL have port full / empty / almost_full / almost_empty  output  1 each  status flags.
REQ-016 SHALL have port error  output  1  sticky overflow/underflow flag.
REQ-017 SHALL have port valid_out  output  1  RAM data_out holds popped word this cycle.
REQ-018 SHALL have port state  output  3  FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3, ERROR=4.

Function
REQ-019 SHALL accept a push iff push=1, full=0, state is IDLE or ACTIVE.
REQ-020 SHALL accept a pop iff pop=1, empty=0, state is IDLE or ACTIVE.
REQ-021 SHALL drive rw combinationally as {pop_accepted, push_accepted}; rw=2'b00 in RESET, INIT, ERROR.
REQ-022 SHALL drive addrw=wr_ptr and addrr=rd_ptr; each pointer increments by 1 on its accepted op, wrapping 2^AW-1 -> 0.
REQ-023 SHALL update count by +1 (push only), -1 (pop only), 0 (both or neither).
REQ-024 SHALL permit simultaneous accepted push and pop when 0 < count < 2^AW.
REQ-025 SHALL, when full, reject push (pop may still be accepted) and set error.
REQ-026 SHALL, when empty, reject pop (push may still be accepted) and set error.
REQ-027 SHALL derive flags combinationally from count: full = count==2^AW; empty = count==0; almost_full = count>=th_af_reg; almost_empty = count<=th_ae_reg.
REQ-028 SHALL assert valid_out, registered, exactly one cycle after each accepted pop (RAM read latency one cycle).
REQ-029 SHALL go RESET->INIT on the first clock edge after reset deasserts.
REQ-030 SHALL, in INIT, latch th_af/th_ae into th_af_reg/th_ae_reg every cycle init=1, clear pointers, count and error.
REQ-031 SHALL go INIT->IDLE on the first edge with init=0.
REQ-032 SHALL go IDLE->ACTIVE on an accepted push, and ACTIVE->IDLE when count becomes 0.
REQ-033 SHALL go to ERROR on the edge at which an overflow or underflow attempt occurs; any op accepted in that same cycle still completes.
REQ-034 SHALL hold ERROR, with error=1 and all requests ignored, until init=1.
REQ-035 SHALL go to INIT from any non-RESET state on init=1; init has priority over push/pop.

Reset
REQ-036 SHALL, while reset=0, asynchronously force: state=RESET, wr_ptr=rd_ptr=0, count=0, error=0, valid_out=0, th_af_reg=AF_DEFAULT, th_ae_reg=AE_DEFAULT.
REQ-037 SHALL, in reset, drive rw=2'b00, addrw=addrr=0, empty=1, full=0, almost_empty=1, almost_full=0.
REQ-038 SHALL, on reset assertion mid-operation, abandon the in-flight op; no write is issued after reset falls.

Verification
REQ-039 SHALL cover: reset, init=1 with th_af=5, th_ae=1, then init=0 -> state INIT then IDLE; thresholds 5/1.
REQ-040 SHALL cover: 8 consecutive pushes -> addrw 0..7, rw=2'b01 each push; count=8, full=1; almost_full from count=5; state ACTIVE.
REQ-041 SHALL cover: a 9th push when full -> rw=2'b00, count stays 8, error=1, state ERROR next cycle.
REQ-042 SHALL cover: init pulse, 3 pushes, then push+pop together -> rw=2'b11, count stays 3, valid_out=1 next cycle.
REQ-043 SHALL cover: pop on empty after init -> rw=2'b00, error=1, state ERROR; a push+pop on empty -> push accepted, error set.
REQ-044 SHALL cover: reset asserted mid-stream with count=4 -> immediate count=0, empty=1, rw=2'b00, state RESET.
